spi_param_target: RTL and testbench



---
 rtl/pedal_pkg.sv | 39 +++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_param_target.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_param_target.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pedal_pkg.sv
// Shared constants for the pedal control path: register map, reset values, SPI target FSM encoding.
package pedal_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned FADDR_W = 7;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned CTRL_W  = 5;

  localparam logic [ADDR_W-1:0] REG_THRES  = 3'd0;
  localparam logic [ADDR_W-1:0] REG_SLOPE  = 3'd1;
  localparam logic [ADDR_W-1:0] REG_GAIN   = 3'd2;
  localparam logic [ADDR_W-1:0] REG_CTRL   = 3'd3;
  localparam logic [ADDR_W-1:0] REG_IMP_LO = 3'd4;
  localparam logic [ADDR_W-1:0] REG_IMP_HI = 3'd5;
  localparam logic [ADDR_W-1:0] REG_STATUS = 3'd6;
  localparam logic [ADDR_W-1:0] REG_ID     = 3'd7;

  localparam int unsigned CTRL_RECORD       = 0;
  localparam int unsigned CTRL_LOOP         = 1;
  localparam int unsigned CTRL_OFF_CHIP_MEM = 2;
  localparam int unsigned CTRL_DELAY_REVERB = 3;
  localparam int unsigned CTRL_MEM_TO_COMP  = 4;

  localparam logic [DATA_W-1:0] THRES_RST  = 8'h80;
  localparam logic [DATA_W-1:0] SLOPE_RST  = 8'h10;
  localparam logic [DATA_W-1:0] GAIN_RST   = 8'h40;
  localparam logic [CTRL_W-1:0] CTRL_RST   = 5'h00;
  localparam logic [DATA_W-1:0] IMP_LO_RST = 8'h00;
  localparam logic [DATA_W-1:0] IMP_HI_RST = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous input with rise/fall detection on the synchronised value.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the raw input through the synchroniser and keep one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout   = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_param_target.sv
// SPI mode-0 target: decodes 16-bit host frames into the pedal parameter registers and answers reads.
module spi_param_target
  import pedal_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [7:0]  ID_VALUE    = 8'hA5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oeb,
  input  logic [7:0]  status_in,
  output logic [7:0]  thres,
  output logic [7:0]  slope,
  output logic [7:0]  gain,
  output logic        record,
  output logic        loop,
  output logic        off_chip_mem,
  output logic        delay_reverb,
  output logic        mem_to_comp,
  output logic [15:0] impulses,
  output logic        wr_pulse,
  output logic [2:0]  wr_addr
);

  logic                   sclk_s, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] cs_sync_q, mosi_sync_q;
  logic                   cs_s, mosi_s, cs_prev_q, cs_fall;

  spi_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-2:0]      rx_q, rx_d;
  logic [DATA_W-1:0]      rx_next;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic                   is_wr_q, is_wr_d;
  logic [FADDR_W-1:0]     addr_q, addr_d;
  logic [FADDR_W-1:0]     addr_new;
  logic                   miso_d, oeb_d, wr_pulse_d;
  logic [ADDR_W-1:0]      wr_addr_d;
  logic [DATA_W-1:0]      thres_d, slope_d, gain_d, imp_lo_d, imp_hi_d;
  logic [DATA_W-1:0]      imp_lo_q, imp_hi_q;
  logic [CTRL_W-1:0]      ctrl_q, ctrl_d;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (sclk),
    .dout   (sclk_s),
    .rise_c (sclk_rise),
    .fall_c (sclk_fall)
  );

  // Plain synchronisers for chip select (idles high) and data in, plus cs_n history for fall detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall = cs_prev_q & ~cs_s;

  // Register value returned for a read of the given frame address
  function automatic logic [DATA_W-1:0] read_value(input logic [FADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (a < FADDR_W'(NUM_REGS)) begin
      case (a[ADDR_W-1:0])
        REG_THRES:  v = thres;
        REG_SLOPE:  v = slope;
        REG_GAIN:   v = gain;
        REG_CTRL:   v = {3'b000, ctrl_q};
        REG_IMP_LO: v = imp_lo_q;
        REG_IMP_HI: v = imp_hi_q;
        REG_STATUS: v = status_in;
        REG_ID:     v = ID_VALUE;
        default:    v = '0;
      endcase
    end
    return v;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, frame shifting, miso generation and write commit
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    miso_d     = miso;
    oeb_d      = miso_oeb;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr;
    thres_d    = thres;
    slope_d    = slope;
    gain_d     = gain;
    ctrl_d     = ctrl_q;
    imp_lo_d   = imp_lo_q;
    imp_hi_d   = imp_hi_q;
    rx_next    = {rx_q, mosi_s};
    addr_new   = rx_next[FADDR_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_ADDR;
          cnt_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
          oeb_d   = 1'b0;
          miso_d  = 1'b0;
        end
      end
      ST_ADDR: begin
        if (cs_s) begin
          state_d = ST_IDLE;
          oeb_d   = 1'b1;
          miso_d  = 1'b0;
        end else if (sclk_rise) begin
          rx_d  = rx_next[DATA_W-2:0];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            is_wr_d = rx_next[DATA_W-1];
            addr_d  = addr_new;
            tx_d    = read_value(addr_new);
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cs_s) begin
          state_d = ST_IDLE;
          oeb_d   = 1'b1;
          miso_d  = 1'b0;
        end else begin
          if (sclk_fall && !is_wr_q) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (sclk_rise) begin
            rx_d  = rx_next[DATA_W-2:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(15)) begin
              state_d = ST_DONE;
              miso_d  = 1'b0;
              if (is_wr_q && (addr_q < FADDR_W'(REG_STATUS))) begin
                wr_pulse_d = 1'b1;
                wr_addr_d  = addr_q[ADDR_W-1:0];
                case (addr_q[ADDR_W-1:0])
                  REG_THRES:  thres_d  = rx_next;
                  REG_SLOPE:  slope_d  = rx_next;
                  REG_GAIN:   gain_d   = rx_next;
                  REG_CTRL:   ctrl_d   = rx_next[CTRL_W-1:0];
                  REG_IMP_LO: imp_lo_d = rx_next;
                  REG_IMP_HI: imp_hi_d = rx_next;
                  default:    ;
                endcase
              end
            end
          end
        end
      end
      ST_DONE: begin
        miso_d = 1'b0;
        if (cs_s) begin
          state_d = ST_IDLE;
          oeb_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath, pad and parameter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      miso     <= 1'b0;
      miso_oeb <= 1'b1;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      thres    <= THRES_RST;
      slope    <= SLOPE_RST;
      gain     <= GAIN_RST;
      ctrl_q   <= CTRL_RST;
      imp_lo_q <= IMP_LO_RST;
      imp_hi_q <= IMP_HI_RST;
    end else begin
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      miso     <= miso_d;
      miso_oeb <= oeb_d;
      wr_pulse <= wr_pulse_d;
      wr_addr  <= wr_addr_d;
      thres    <= thres_d;
      slope    <= slope_d;
      gain     <= gain_d;
      ctrl_q   <= ctrl_d;
      imp_lo_q <= imp_lo_d;
      imp_hi_q <= imp_hi_d;
    end
  end

  assign record       = ctrl_q[CTRL_RECORD];
  assign loop         = ctrl_q[CTRL_LOOP];
  assign off_chip_mem = ctrl_q[CTRL_OFF_CHIP_MEM];
  assign delay_reverb = ctrl_q[CTRL_DELAY_REVERB];
  assign mem_to_comp  = ctrl_q[CTRL_MEM_TO_COMP];
  assign impulses     = {imp_hi_q, imp_lo_q};

endmodule

// File: tb/tb_spi_param_target.sv
// Directed bench for spi_param_target: host frames at sclk = clk/8 with hand-computed expectations.
module tb_spi_param_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oeb;
  logic [7:0]  status_in = 8'h3C;
  logic [7:0]  thres, slope, gain;
  logic        record, loop, off_chip_mem, delay_reverb, mem_to_comp;
  logic [15:0] impulses;
  logic        wr_pulse;
  logic [2:0]  wr_addr;

  int          total = 0;
  int          bad = 0;
  int          pulse_cnt = 0;
  logic [2:0]  last_addr = 3'd0;
  logic        oeb_mid;
  logic [7:0]  rd;
  int          p0;

  always #5 clk = ~clk;

  spi_param_target dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oeb     (miso_oeb),
    .status_in    (status_in),
    .thres        (thres),
    .slope        (slope),
    .gain         (gain),
    .record       (record),
    .loop         (loop),
    .off_chip_mem (off_chip_mem),
    .delay_reverb (delay_reverb),
    .mem_to_comp  (mem_to_comp),
    .impulses     (impulses),
    .wr_pulse     (wr_pulse),
    .wr_addr      (wr_addr)
  );

  // Count write strobes (one count per clk cycle high) and remember the strobed address
  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      last_addr = wr_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive nbits host clocks of frame f with cs_n low; captures miso on rising edges 9..16
  task automatic send_bits(input logic [15:0] f, input int nbits);
    logic [15:0] fv;
    fv = f;
    rd = 8'h00;
    @(negedge clk);
    cs_n = 1'b0;
    mosi = fv[15];
    for (int i = 0; i < nbits; i++) begin
      repeat (4) @(negedge clk);
      if (i >= 8 && i < 16) rd[15-i] = miso;
      if (i == 8) oeb_mid = miso_oeb;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      mosi = (i + 1 < 16) ? fv[14-i] : 1'b1;
    end
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] f);
    send_bits(f, 16);
    end_frame();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_thres", 32'(thres), 32'h80);
    chk("rst_slope", 32'(slope), 32'h10);
    chk("rst_gain", 32'(gain), 32'h40);
    chk("rst_ctrl", 32'({mem_to_comp, delay_reverb, off_chip_mem, loop, record}), 32'h00);
    chk("rst_imp", 32'(impulses), 32'h0000);
    chk("rst_oeb", 32'(miso_oeb), 32'h1);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_wrp", 32'(wr_pulse), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write threshold
    p0 = pulse_cnt;
    frame(16'h803C);
    chk("wr_thres", 32'(thres), 32'h3C);
    chk("wr_thres_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("wr_thres_addr", 32'(last_addr), 32'd0);
    chk("wr_thres_miso", 32'(rd), 32'h00);
    chk("wr_thres_slope", 32'(slope), 32'h10);
    chk("wr_thres_gain", 32'(gain), 32'h40);
    chk("wr_thres_imp", 32'(impulses), 32'h0000);

    // Read ID
    send_bits(16'h0700, 16);
    chk("id_oeb_mid", 32'(oeb_mid), 32'h0);
    chk("id_oeb_low", 32'(miso_oeb), 32'h0);
    end_frame();
    chk("id_val", 32'(rd), 32'hA5);
    chk("id_oeb_after", 32'(miso_oeb), 32'h1);

    // Impulses write and read-back
    p0 = pulse_cnt;
    frame(16'h8412);
    frame(16'h85AB);
    chk("imp_val", 32'(impulses), 32'hAB12);
    chk("imp_pulses", 32'(pulse_cnt - p0), 32'd2);
    chk("imp_last_addr", 32'(last_addr), 32'd5);
    frame(16'h0400);
    chk("rd_imp_lo", 32'(rd), 32'h12);
    frame(16'h0300);
    chk("rd_ctrl0", 32'(rd), 32'h00);

    // Control bits: upper three bits dropped
    frame(16'h83FF);
    chk("ctrl_bits", 32'({mem_to_comp, delay_reverb, off_chip_mem, loop, record}), 32'h1F);
    frame(16'h0300);
    chk("rd_ctrl1", 32'(rd), 32'h1F);

    // Abort after 10 bits, then full frame
    p0 = pulse_cnt;
    send_bits(16'h8255, 10);
    end_frame();
    chk("abort_gain", 32'(gain), 32'h40);
    chk("abort_pulses", 32'(pulse_cnt - p0), 32'd0);
    frame(16'h8255);
    chk("gain_full", 32'(gain), 32'h55);
    chk("gain_addr", 32'(last_addr), 32'd2);

    // Read-only and unmapped
    p0 = pulse_cnt;
    frame(16'h86FF);
    frame(16'hFF12);
    chk("ro_pulses", 32'(pulse_cnt - p0), 32'd0);
    chk("ro_thres", 32'(thres), 32'h3C);
    frame(16'h0600);
    chk("rd_status", 32'(rd), 32'h3C);
    frame(16'h7F00);
    chk("rd_unmapped", 32'(rd), 32'h00);

    // Extra clocks beyond 16 are ignored
    p0 = pulse_cnt;
    send_bits(16'h8077, 20);
    end_frame();
    chk("extra_thres", 32'(thres), 32'h77);
    chk("extra_pulses", 32'(pulse_cnt - p0), 32'd1);

    // Reset in the middle of a data phase
    p0 = pulse_cnt;
    send_bits(16'h8101, 12);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_slope", 32'(slope), 32'h10);
    chk("mid_rst_oeb", 32'(miso_oeb), 32'h1);
    chk("mid_rst_thres", 32'(thres), 32'h80);
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_pulses", 32'(pulse_cnt - p0), 32'd0);
    frame(16'h8101);
    chk("post_rst_slope", 32'(slope), 32'h01);
    chk("post_rst_gain", 32'(gain), 32'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
